pool_buffer: RTL
================

# pool_buffer

Ping-pong feature-map buffer that sits directly downstream of `conv_mix_6`. It captures the six parallel 16-bit pooled channels on each all-channel valid pulse and stores one complete pooled frame per bank. It then replays finished frames in raster order through a valid/ready stream, which feeds the next layer's `din_0..din_5` inputs. While one bank drains, the other fills.

## Interface
Parameters:
- `DW`, 16: sample width; signed two's complement.
- `NCH`, 6: number of parallel channels.
- `DEPTH0`, 144: frame length in mode 0 (12×12 pooled samples).
- `DEPTH1`, 16: frame length in mode 1 (4×4 pooled samples).

Ports:
- `clk`  in  1  the only clock; rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `state`  in  1  layer mode; selects `DEPTH0` (0) or `DEPTH1` (1).
- `in_valid`  in  6  per-channel valid, driven from the upstream `ovalid`.
- `in_data_0..in_data_5`  in  DW each  pooled samples.
- `out_ready`  in  1  consumer accepts the current word.
- `out_valid`  out  1  `out_data_*` holds a valid word.
- `out_data_0..out_data_5`  out  DW each  replayed samples.
- `out_last`  out  1  marks the final word of a frame; qualified by `out_valid`.
- `bank_full`  out  2  per-bank full flag.
- `err`  out  2  sticky flags. Bit0 = write dropped because no free bank. Bit1 = partial `in_valid` (neither all-zero nor all-one). Both are cleared only by reset.

## Operation
- Frame length: L = `DEPTH0` if `state`=0, else `DEPTH1`.
- Write acceptance: a write occurs when `in_valid`==6'b111111.
  - The six samples are stored at `wr_addr` of `wr_bank`, and `wr_addr` increments.
  - On the write where `wr_addr`==L-1: set `bank_full[wr_bank]`, clear `wr_addr` to 0, and toggle `wr_bank`.
- No free bank: if `bank_full[wr_bank]` is already 1, the write is dropped, `err[0]` is set, and the pointers do not change.
- Partial valid: `in_valid` neither 0 nor all-ones sets `err[1]`, and nothing is written.
- Fill order: banks fill 0,1,0,1,… Replay always takes the oldest full bank, tracked by `rd_bank`, which toggles in step with `wr_bank`.
- Replay:
  - When `bank_full[rd_bank]`=1, words at `rd_addr` 0..L-1 are presented in order.
  - A transfer occurs on `out_valid`&&`out_ready`.
  - `out_last`=1 on the word with `rd_addr`==L-1.
  - When the last word transfers: clear `bank_full[rd_bank]`, toggle `rd_bank`, and set `rd_addr` to 0.
- Mode change: a change of `state` (detected against a registered copy) performs a soft clear on the next edge. It clears `wr_addr`, `rd_addr`, `wr_bank`, `rd_bank`, `bank_full`, `out_valid` and `out_last`. It does not clear `err`. Any partial frame is discarded.
- Arithmetic: samples are stored and replayed unmodified. There is no saturation or sign change.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data_*`=0, `bank_full`=2'b00, `err`=2'b00, all pointers 0.
- Fill latency: the write edge that completes a frame sets `bank_full` at that same edge. `out_valid` rises 2 cycles later (1 cycle of RAM read latency plus 1 output-register cycle).
- Hold rule: while `out_valid`=1 and `out_ready`=0, `out_data_*` and `out_last` hold stable.
- Throughput: with `out_ready` held high, one word transfers per cycle with no bubbles inside a frame. This requires prefetch with a skid register.
- Back-to-back frames: if the other bank is already full when `out_last` transfers, its word 0 is valid on the next cycle. There is no gap.
- Simultaneous events:
  - A frame-completing write and a last-word release on the other bank in the same cycle both take effect.
  - A write to a bank in the same cycle that its release occurs is dropped (`err[0]`). The bank is free from the following cycle.
- Reset mid-frame: asynchronous assertion forces all reset values immediately. Partial data is lost.

## Structure
- Shared package constants: `DW`, `NCH`, `DEPTH0`, `DEPTH1`, and the mode encoding (0 = 6-channel layer, 1 = summed layer).
- Sub-module `fmap_ram`:
  - Simple dual-port RAM: one write port and one read port.
  - Width `NCH*DW`, depth 2×`DEPTH0`; address = {bank, addr}.
  - Registered read, 1-cycle latency, no reset on the array.
- Top level holds the write/read pointers, bank flags, error logic and the output skid stage.

## Test plan
- Mode 0 fill and drain: 144 all-valid writes with `in_data_k`=k*1000+i, `out_ready`=1 → `out_valid` rises 2 cycles after the last write. Words i=0..143 come out in order with no gaps; `out_last` only at i=143; `bank_full` returns to 00.
- Backpressure: during replay, toggle `out_ready` 1,0,0,1 → no duplicate or lost words; `out_data` is stable across stalled cycles.
- Ping-pong: mode 1, 48 writes with `out_ready`=0 → the first 32 fill both banks (`bank_full`=11); the last 16 set `err[0]`. Raise `out_ready` → 32 words come out, bank 0 then bank 1, contiguous.
- Partial valid: `in_valid`=6'b000011 for one cycle → `err[1]`=1 and `wr_addr` is unchanged.
- Mode change: 50 writes in mode 0, then `state`→1 → `wr_addr`=0 and no output. 16 further writes → exactly 16 words replayed.
- Async reset: assert `rstn`=0 mid-replay between clock edges → `out_valid`, `bank_full` and `err` are 0 immediately.

Source files
------------

// File: rtl/pool_buffer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pool_buffer_pkg : shared sizes and layer-mode encoding for pool_buffer
// Rev 1.0
// ----------------------------------------------------------------------------
package pool_buffer_pkg;

  localparam int POOL_DW     = 16;
  localparam int POOL_NCH    = 6;
  localparam int POOL_DEPTH0 = 144;
  localparam int POOL_DEPTH1 = 16;

  typedef enum logic {
    MODE_CH6 = 1'b0,
    MODE_SUM = 1'b1
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/pool_buffer_fmap_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pool_buffer_fmap_ram : two-bank simple dual-port RAM, registered read
// Rev 1.0
// ----------------------------------------------------------------------------
module pool_buffer_fmap_ram #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 144,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int IW = $clog2(2 * DEPTH);

  logic [WIDTH-1:0] mem [2*DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  // Bank 1 occupies the upper DEPTH entries.
  assign wr_idx = wr_bank ? IW'(DEPTH) + IW'(wr_addr) : IW'(wr_addr);
  assign rd_idx = rd_bank ? IW'(DEPTH) + IW'(rd_addr) : IW'(rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data_q <= mem[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/pool_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pool_buffer : ping-pong pooled-frame buffer replayed as a valid/ready stream
// Rev 1.0
// ----------------------------------------------------------------------------
module pool_buffer
  import pool_buffer_pkg::*;
#(
  parameter int DW     = POOL_DW,
  parameter int NCH    = POOL_NCH,
  parameter int DEPTH0 = POOL_DEPTH0,
  parameter int DEPTH1 = POOL_DEPTH1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           state,
  input  logic [NCH-1:0] in_valid,
  input  logic [DW-1:0]  in_data_0,
  input  logic [DW-1:0]  in_data_1,
  input  logic [DW-1:0]  in_data_2,
  input  logic [DW-1:0]  in_data_3,
  input  logic [DW-1:0]  in_data_4,
  input  logic [DW-1:0]  in_data_5,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [DW-1:0]  out_data_0,
  output logic [DW-1:0]  out_data_1,
  output logic [DW-1:0]  out_data_2,
  output logic [DW-1:0]  out_data_3,
  output logic [DW-1:0]  out_data_4,
  output logic [DW-1:0]  out_data_5,
  output logic           out_last,
  output logic [1:0]     bank_full,
  output logic [1:0]     err
);

  localparam int AW = $clog2(DEPTH0);
  localparam int WW = NCH * DW;

  mode_e          state_q, state_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d, fetch_addr_q, fetch_addr_d;
  logic           wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, fetch_bank_q, fetch_bank_d;
  logic [1:0]     bank_full_q, bank_full_d, err_q, err_d;
  logic           ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic           out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic           skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic [WW-1:0]  out_data_q, out_data_d, skid_data_q, skid_data_d;

  logic [WW-1:0]  wr_data, ram_rdata;
  logic [AW-1:0]  len_m1;
  logic [2:0]     inflight;
  logic           mode_chg, all_v, part_v, drop, wr_en, pop, release_bank, issue;

  assign wr_data  = {in_data_5, in_data_4, in_data_3, in_data_2, in_data_1, in_data_0};
  assign len_m1   = (state_q == MODE_SUM) ? AW'(DEPTH1 - 1) : AW'(DEPTH0 - 1);
  assign mode_chg = (state != state_q);
  assign all_v    = &in_valid;
  assign part_v   = (|in_valid) && !all_v;
  assign drop     = all_v && !mode_chg && bank_full_q[wr_bank_q];
  assign wr_en    = all_v && !mode_chg && !bank_full_q[wr_bank_q];
  assign pop      = out_valid_q && out_ready;
  assign release_bank = pop && out_last_q;

  // Words already read or buffered after this edge; at most two may sit in
  // the output + skid registers, so a new read needs fewer than two pending.
  assign inflight = {2'b00, ram_vld_q} + {2'b00, out_valid_q} + {2'b00, skid_valid_q}
                  - {2'b00, pop};
  assign issue    = bank_full_q[fetch_bank_q] && !mode_chg && (inflight < 3'd2);

  pool_buffer_fmap_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH0),
    .AW    (AW)
  ) u_fmap_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data),
    .rd_bank (fetch_bank_q),
    .rd_addr (fetch_addr_q),
    .rd_data (ram_rdata)
  );

  always_comb begin
    state_d      = mode_e'(state);
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    fetch_addr_d = fetch_addr_q;
    fetch_bank_d = fetch_bank_q;
    bank_full_d  = bank_full_q;
    err_d        = err_q | {part_v, drop};
    ram_vld_d    = issue;
    ram_last_d   = (fetch_addr_q == len_m1);
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;

    if (release_bank) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    if (wr_en) begin
      if (wr_addr_q == len_m1) begin
        wr_addr_d              = '0;
        wr_bank_d              = ~wr_bank_q;
        bank_full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end

    // Fetch runs ahead of the consumer and may already be in the other bank.
    if (issue) begin
      if (fetch_addr_q == len_m1) begin
        fetch_addr_d = '0;
        fetch_bank_d = ~fetch_bank_q;
      end else begin
        fetch_addr_d = fetch_addr_q + AW'(1);
      end
    end

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_data_d   = skid_data_q;
        skid_valid_d = ram_vld_q;
        skid_last_d  = ram_last_q;
        skid_data_d  = ram_rdata;
      end else begin
        out_valid_d = ram_vld_q;
        out_last_d  = ram_vld_q && ram_last_q;
        if (ram_vld_q) begin
          out_data_d = ram_rdata;
        end
      end
    end else if (ram_vld_q) begin
      skid_valid_d = 1'b1;
      skid_last_d  = ram_last_q;
      skid_data_d  = ram_rdata;
    end

    if (mode_chg) begin
      wr_addr_d    = '0;
      wr_bank_d    = 1'b0;
      rd_bank_d    = 1'b0;
      fetch_addr_d = '0;
      fetch_bank_d = 1'b0;
      bank_full_d  = 2'b00;
      ram_vld_d    = 1'b0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      skid_valid_d = 1'b0;
      skid_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= MODE_CH6;
      wr_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      fetch_addr_q <= '0;
      fetch_bank_q <= 1'b0;
      bank_full_q  <= 2'b00;
      err_q        <= 2'b00;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_bank_q <= fetch_bank_d;
      bank_full_q  <= bank_full_d;
      err_q        <= err_d;
      ram_vld_q    <= ram_vld_d;
      ram_last_q   <= ram_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign bank_full  = bank_full_q;
  assign err        = err_q;
  assign out_data_0 = out_data_q[0*DW +: DW];
  assign out_data_1 = out_data_q[1*DW +: DW];
  assign out_data_2 = out_data_q[2*DW +: DW];
  assign out_data_3 = out_data_q[3*DW +: DW];
  assign out_data_4 = out_data_q[4*DW +: DW];
  assign out_data_5 = out_data_q[5*DW +: DW];

endmodule
`default_nettype wire
